seg_scan_decoder: RTL

- Receive end of the multiplexed 7-segment interface (seg[6:0], an[3:0]) that the display driver in top produces.
- Samples the scanned segment/anode lines and waits for each dwell to settle.
- Decodes each glyph back to a BCD nibble and assembles the four digit positions into a frame.
- Used in the bench and for on-board loopback checking of the display path.

---
 rtl/seg7_pkg.sv | 29 ++
 rtl/seg7_glyph_decode.sv | 30 +++
 rtl/seg_scan_decoder.sv | 128 ++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-high glyphs (bit0=a .. bit6=g),
// special nibble codes and the scan decoder state encoding.
package seg7_pkg;

   localparam logic [6:0] GLYPH_0 = 7'h3F;
   localparam logic [6:0] GLYPH_1 = 7'h06;
   localparam logic [6:0] GLYPH_2 = 7'h5B;
   localparam logic [6:0] GLYPH_3 = 7'h4F;
   localparam logic [6:0] GLYPH_4 = 7'h66;
   localparam logic [6:0] GLYPH_5 = 7'h6D;
   localparam logic [6:0] GLYPH_6 = 7'h7D;
   localparam logic [6:0] GLYPH_7 = 7'h07;
   localparam logic [6:0] GLYPH_8 = 7'h7F;
   localparam logic [6:0] GLYPH_9 = 7'h6F;
   localparam logic [6:0] GLYPH_BLANK = 7'h00;

   localparam logic [3:0] NIBBLE_BLANK = 4'hF;
   localparam logic [3:0] NIBBLE_BAD   = 4'hE;

   typedef enum logic {
      SETTLE = 1'b0,
      HELD   = 1'b1
   } scan_state_t;

   function automatic logic is_onehot4(input logic [3:0] v);
      return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
   endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational 7-segment glyph to BCD decoder. Blank glyph gives NIBBLE_BLANK,
// anything unrecognised gives NIBBLE_BAD with err set.
module seg7_glyph_decode
   import seg7_pkg::*;
(
   input  logic [6:0] glyph,
   output logic [3:0] nibble,
   output logic       err
);

   always_comb begin
      nibble = NIBBLE_BAD;
      err    = 1'b1;
      case (glyph)
         GLYPH_0:     begin nibble = 4'd0; err = 1'b0; end
         GLYPH_1:     begin nibble = 4'd1; err = 1'b0; end
         GLYPH_2:     begin nibble = 4'd2; err = 1'b0; end
         GLYPH_3:     begin nibble = 4'd3; err = 1'b0; end
         GLYPH_4:     begin nibble = 4'd4; err = 1'b0; end
         GLYPH_5:     begin nibble = 4'd5; err = 1'b0; end
         GLYPH_6:     begin nibble = 4'd6; err = 1'b0; end
         GLYPH_7:     begin nibble = 4'd7; err = 1'b0; end
         GLYPH_8:     begin nibble = 4'd8; err = 1'b0; end
         GLYPH_9:     begin nibble = 4'd9; err = 1'b0; end
         GLYPH_BLANK: begin nibble = NIBBLE_BLANK; err = 1'b0; end
         default:     begin nibble = NIBBLE_BAD; err = 1'b1; end
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive side of a multiplexed 7-segment scan: waits for each anode dwell to
// settle, samples it once, decodes the glyph and assembles 4-digit frames.
module seg_scan_decoder
   import seg7_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 4,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  seg_in,
   input  logic [3:0]  an_in,
   output logic [15:0] digits_o,
   output logic [3:0]  digit_err_o,
   output logic        frame_valid_o,
   output logic        scan_err_o
);

   localparam int CW = $clog2(SETTLE_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

   logic [3:0]    an_raw_reg, an_prev_reg;
   logic [6:0]    seg_raw_reg, seg_prev_reg;
   logic [3:0]    an_act;
   logic [6:0]    seg_act;
   logic          changed;

   scan_state_t   state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic          sample;

   logic [3:0]    dec_nibble;
   logic          dec_err;
   logic          digit_sample, illegal_sample, frame_done;
   logic [3:0]    seen_reg, seen_set, seen_all;
   logic [15:0]   stage_reg, stage_next;
   logic [3:0]    stage_err_reg, stage_err_next;

   assign an_act  = AN_ACTIVE_LOW  ? ~an_raw_reg  : an_raw_reg;
   assign seg_act = SEG_ACTIVE_LOW ? ~seg_raw_reg : seg_raw_reg;
   assign changed = (an_raw_reg != an_prev_reg) || (seg_raw_reg != seg_prev_reg);

   // One sample per dwell: SETTLE counts up to the threshold, HELD waits for the next change.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      sample     = 1'b0;
      if (changed) begin
         cnt_next   = '0;
         state_next = SETTLE;
      end else begin
         case (state_reg)
            SETTLE: begin
               if (cnt_reg >= CNT_LAST) begin
                  sample     = 1'b1;
                  state_next = HELD;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
            HELD: begin
               if (cnt_reg != CNT_MAX) cnt_next = cnt_reg + 1'b1;
            end
            default: state_next = SETTLE;
         endcase
      end
   end

   seg7_glyph_decode u_glyph (
      .glyph  (seg_act),
      .nibble (dec_nibble),
      .err    (dec_err)
   );

   assign digit_sample   = sample && is_onehot4(an_act);
   assign illegal_sample = sample && (an_act != 4'b0000) && !is_onehot4(an_act);
   assign seen_set       = digit_sample ? an_act : 4'b0000;
   assign seen_all       = seen_reg | seen_set;
   assign frame_done     = digit_sample && (seen_all == 4'b1111);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_pos
         assign stage_next[4*gi +: 4] = seen_set[gi] ? dec_nibble : stage_reg[4*gi +: 4];
         assign stage_err_next[gi]    = seen_set[gi] ? dec_err    : stage_err_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         an_raw_reg    <= '0;
         an_prev_reg   <= '0;
         seg_raw_reg   <= '0;
         seg_prev_reg  <= '0;
         state_reg     <= SETTLE;
         cnt_reg       <= '0;
         seen_reg      <= '0;
         stage_reg     <= '0;
         stage_err_reg <= '0;
         digits_o      <= '0;
         digit_err_o   <= '0;
         frame_valid_o <= 1'b0;
         scan_err_o    <= 1'b0;
      end else begin
         an_raw_reg    <= an_in;
         an_prev_reg   <= an_raw_reg;
         seg_raw_reg   <= seg_in;
         seg_prev_reg  <= seg_raw_reg;
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         stage_reg     <= stage_next;
         stage_err_reg <= stage_err_next;
         frame_valid_o <= frame_done;
         scan_err_o    <= illegal_sample;
         // Publishing uses the merged staging so the completing digit lands in this frame.
         if (frame_done) begin
            digits_o    <= stage_next;
            digit_err_o <= stage_err_next;
            seen_reg    <= '0;
         end else begin
            seen_reg    <= seen_all;
         end
      end
   end

endmodule
